addsub_sat_pipe: RTL

//  Parametrised, pipelined signed add/subtract unit with optional saturation and valid/ready flow control.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_sat_pipe_if.sv | 25 ++
 rtl/cla_block.sv | 36 +++
 rtl/addsub_sat_pipe.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and saturation helpers for the pipelined signed add/sub unit.
package addsub_pkg;

  localparam int SAT_MAXW = 64;

  typedef logic [SAT_MAXW-1:0] sat_word_t;

  typedef struct packed {
    logic sub;
    logic sat;
  } op_tag_t;

  function automatic sat_word_t sat_max(input int width);
    return (sat_word_t'(1) << (width - 1)) - sat_word_t'(1);
  endfunction

  function automatic sat_word_t sat_min(input int width);
    return sat_word_t'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_sat_pipe_if.sv
// Request/response bus of the add/sub pipe: operand handshake, result handshake, sticky flag.
interface addsub_sat_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Ovfl;
  logic             ovfl_sticky;
  logic             clr_sticky;

  modport master (
    output in_valid, A, B, sub, sat, out_ready, clr_sticky,
    input  in_ready, out_valid, Sum, Ovfl, ovfl_sticky
  );

  modport slave (
    input  in_valid, A, B, sub, sat, out_ready, clr_sticky,
    output in_ready, out_valid, Sum, Ovfl, ovfl_sticky
  );
endinterface

// File: rtl/cla_block.sv
// BLK-bit carry-lookahead adder; every carry is a flat sum of products of g/p and cin.
module cla_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout
);
  logic [BLK-1:0] w_g, w_p;
  logic [BLK:0]   w_c;
  logic           w_acc, w_prod;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    w_acc  = 1'b0;
    w_prod = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      w_acc  = w_g[i];
      w_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_g[j]);
        w_prod = w_prod & w_p[j];
      end
      w_c[i+1] = w_acc | (w_prod & cin);
    end
  end

  assign s    = w_p ^ w_c[BLK-1:0];
  assign cout = w_c[BLK];
endmodule

// File: rtl/addsub_sat_pipe.sv
// Pipelined signed add/sub with optional saturation, sticky overflow and valid/ready flow control.
// Stage k adds its group of CLA blocks and hands the not-yet-added operand bits forward.
module addsub_sat_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  addsub_sat_pipe_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int BPS  = NBLK / STAGES;
  localparam int SW   = BPS * BLK;
  localparam int L    = STAGES - 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic [STAGES-1:0] r_v, w_adv, w_ld;
  logic [WIDTH-1:0]  w_bx_in;
  op_tag_t           w_tag_in;
  logic              w_cmsb, w_ovfl, r_sticky;

  assign w_bx_in  = bus.sub ? ~bus.B : bus.B;
  assign w_tag_in = '{sub: bus.sub, sat: bus.sat};

  always_comb begin
    w_adv    = '0;
    w_adv[L] = r_v[L] & bus.out_ready;
    for (int k = L - 1; k >= 0; k--)
      w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
  end

  // stage k loads exactly what stage k-1 releases
  always_comb begin
    w_ld    = w_adv << 1;
    w_ld[0] = bus.in_valid & bus.in_ready;
  end

  assign bus.in_ready = ~r_v[0] | w_adv[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v      <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_v <= w_ld | (r_v & ~w_adv);
      if (w_adv[L] && w_ovfl)
        r_sticky <= 1'b1;
      else if (bus.clr_sticky)
        r_sticky <= 1'b0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = (k + 1) * SW;
    localparam int REM = WIDTH - k * SW;

    logic [REM-1:0] w_ain, w_bin;
    logic [SW-1:0]  w_s;
    logic           w_c [0:BPS];
    logic           w_amsb, w_bmsb;
    op_tag_t        w_tin;

    logic [LO-1:0]  r_s;
    logic           r_c, r_amsb, r_bmsb;
    op_tag_t        r_tag;

    if (k == 0) begin : g_src
      assign w_ain  = bus.A;
      assign w_bin  = w_bx_in;
      assign w_c[0] = bus.sub;
      assign w_tin  = w_tag_in;
      assign w_amsb = bus.A[WIDTH-1];
      assign w_bmsb = bus.B[WIDTH-1];
    end else begin : g_src
      assign w_ain  = g_st[k-1].g_hi.r_ahi;
      assign w_bin  = g_st[k-1].g_hi.r_bhi;
      assign w_c[0] = g_st[k-1].r_c;
      assign w_tin  = g_st[k-1].r_tag;
      assign w_amsb = g_st[k-1].r_amsb;
      assign w_bmsb = g_st[k-1].r_bmsb;
    end

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      cla_block #(.BLK(BLK)) u_cla (
        .a    (w_ain[j*BLK +: BLK]),
        .b    (w_bin[j*BLK +: BLK]),
        .cin  (w_c[j]),
        .s    (w_s[j*BLK +: BLK]),
        .cout (w_c[j+1])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_c    <= 1'b0;
        r_tag  <= '0;
        r_amsb <= 1'b0;
        r_bmsb <= 1'b0;
      end else if (w_ld[k]) begin
        r_c    <= w_c[BPS];
        r_tag  <= w_tin;
        r_amsb <= w_amsb;
        r_bmsb <= w_bmsb;
      end
    end

    if (k == 0) begin : g_sum
      always_ff @(posedge clk or posedge rst)
        if (rst)         r_s <= '0;
        else if (w_ld[k]) r_s <= w_s;
    end else begin : g_sum
      always_ff @(posedge clk or posedge rst)
        if (rst)         r_s <= '0;
        else if (w_ld[k]) r_s <= {w_s, g_st[k-1].r_s};
    end

    if (k < L) begin : g_hi
      logic [REM-SW-1:0] r_ahi, r_bhi;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          r_ahi <= '0;
          r_bhi <= '0;
        end else if (w_ld[k]) begin
          r_ahi <= w_ain[REM-1:SW];
          r_bhi <= w_bin[REM-1:SW];
        end
    end
  end

  // carry into the MSB recovered from the sum bit and the MSBs of A and Bx
  assign w_cmsb = g_st[L].r_s[WIDTH-1] ^ g_st[L].r_amsb ^ g_st[L].r_bmsb ^ g_st[L].r_tag.sub;
  assign w_ovfl = g_st[L].r_c ^ w_cmsb;

  assign bus.out_valid   = r_v[L];
  assign bus.Ovfl        = w_ovfl;
  assign bus.ovfl_sticky = r_sticky;
  assign bus.Sum         = (g_st[L].r_tag.sat && w_ovfl) ? (g_st[L].r_amsb ? SMIN : SMAX)
                                                        : g_st[L].r_s;
endmodule
